// File: rtl/pwm_bank_pkg.sv
// Shared register map and parameter legality helpers for the pwm_bank PWM generator.
package pwm_bank_pkg;

    localparam logic [3:0] ADDR_EN    = 4'h0;
    localparam logic [3:0] ADDR_PRESC = 4'h1;
    localparam logic [3:0] ADDR_DUTY0 = 4'h2;

    localparam int CNT_W_MIN = 4;
    localparam int CNT_W_MAX = 8;

    function automatic bit cnt_w_legal(input int w);
        return (w >= CNT_W_MIN) && (w <= CNT_W_MAX);
    endfunction

endpackage

// File: rtl/pwm_bank_chan.sv
// One PWM channel: active duty (plus shadow copy when PWM_BANK_SHADOW_EN is defined)
// and the registered compare output.
module pwm_bank_chan
    import pwm_bank_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             en,
    input  logic             duty_wr,
    input  logic [CNT_W-1:0] duty_wdata,
    input  logic             wrap_tick,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm_o
);

    logic [CNT_W-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;

`ifdef PWM_BANK_SHADOW_EN
    logic [CNT_W-1:0] shadow_q, shadow_d;

    // A write coinciding with the wrap lands in the shadow; active takes the old shadow.
    always_comb begin
        shadow_d = duty_wr ? duty_wdata : shadow_q;
        duty_d   = wrap_tick ? shadow_q : duty_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shadow_q <= '0;
        else        shadow_q <= shadow_d;
    end
`else
    logic unused_wrap;

    always_comb begin
        duty_d      = duty_wr ? duty_wdata : duty_q;
        unused_wrap = wrap_tick;
    end
`endif

    // Full-scale duty is constant high rather than one count short.
    always_comb begin
        pwm_d = ena && en && (duty_q != '0) && ((cnt < duty_q) || (duty_q == '1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: prescaler, shared period counter, register writes, N_CH channels.
// Optional shadowed duty registers with macro PWM_BANK_SHADOW_EN.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic            wr_en,
    input  logic [3:0]      wr_addr,
    input  logic [7:0]      wr_data,
    output logic [N_CH-1:0] pwm_out,
    output logic            wrap_o
);

    if (!cnt_w_legal(CNT_W)) begin : g_bad_cnt_w
        $error("pwm_bank: CNT_W must be 4..8");
    end
    if ((N_CH < 1) || (N_CH > 8)) begin : g_bad_n_ch
        $error("pwm_bank: N_CH must be 1..8");
    end

    logic [N_CH-1:0]  en_q, en_d;
    logic [7:0]       presc_q, presc_d;
    logic [7:0]       pcnt_q, pcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             tick, wrap_tick, wr_mask, wr_presc;
    logic [N_CH-1:0]  duty_wr;

    always_comb begin
        tick      = ena && (pcnt_q == presc_q);
        wrap_tick = tick && (cnt_q == '1);
        wr_mask   = wr_en && (wr_addr == ADDR_EN);
        wr_presc  = wr_en && (wr_addr == ADDR_PRESC);
        en_d      = wr_mask ? wr_data[N_CH-1:0] : en_q;
        presc_d   = wr_presc ? wr_data : presc_q;
        // A new prescale value restarts the divider so the next tick is a full interval away.
        pcnt_d    = pcnt_q;
        if (wr_presc || tick) pcnt_d = '0;
        else if (ena)         pcnt_d = pcnt_q + 8'd1;
        cnt_d     = tick ? cnt_q + CNT_W'(1) : cnt_q;
        wrap_d    = wrap_tick;
        duty_wr   = '0;
        for (int i = 0; i < N_CH; i++) begin
            duty_wr[i] = wr_en && (wr_addr == ADDR_DUTY0 + 4'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= '0;
            presc_q <= '0;
            pcnt_q  <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            en_q    <= en_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        pwm_bank_chan #(.CNT_W(CNT_W)) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .ena        (ena),
            .en         (en_q[g]),
            .duty_wr    (duty_wr[g]),
            .duty_wdata (wr_data[CNT_W-1:0]),
            .wrap_tick  (wrap_tick),
            .cnt        (cnt_q),
            .pwm_o      (pwm_out[g])
        );
    end

    assign wrap_o = wrap_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Testbench for pwm_bank: vector table of configurations scored per period, plus
// hand sequences for reset, enable hold, prescaler restart and duty update timing.
module tb_pwm_bank;
    import pwm_bank_pkg::*;

    localparam int N_CH  = 8;
    localparam int CNT_W = 8;
`ifdef PWM_BANK_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ena = 1'b1;
    logic            wr_en = 1'b0;
    logic [3:0]      wr_addr = 4'h0;
    logic [7:0]      wr_data = 8'h00;
    logic [N_CH-1:0] pwm_out;
    logic            wrap_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int per; int hi0; int hi1; int hirest; int rise0; int rise1;
    } res_t;

    typedef struct {
        logic [7:0] presc; logic [7:0] mask; logic [7:0] d0; logic [7:0] d1;
        int nper; int e_per; int e_hi0; int e_hi1;
    } vec_t;

    vec_t vt[7];
    res_t sb[$];

    always #5 clk = ~clk;

    pwm_bank #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .pwm_out (pwm_out),
        .wrap_o  (wrap_o)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Steps until wrap_o is seen; n = cycles taken, hi = cycles with any pwm_out bit high.
    task automatic wait_wrap(input int limit, input string nm, output int n, output int hi);
        n = 0; hi = 0;
        do begin
            step();
            n++;
            if (pwm_out != '0) hi++;
        end while (!wrap_o && n < limit);
        if (!wrap_o) begin
            total++; bad++;
            $display("FAIL %s_timeout: no wrap_o within %0d cycles", nm, limit);
        end
    endtask

    // Starting on a wrap_o cycle, runs to the next wrap_o; optional write driven after sample wr_at.
    task automatic run_period(input int wr_at, input logic [3:0] a, input logic [7:0] d,
                              input int limit, output res_t r);
        r = '{default: 0};
        for (int k = 1; k <= limit; k++) begin
            if (k - 1 == wr_at) begin
                wr_en = 1'b1; wr_addr = a; wr_data = d;
            end else begin
                wr_en = 1'b0;
            end
            step();
            if (pwm_out[0]) begin r.hi0++; if (r.rise0 == 0) r.rise0 = k; end
            if (pwm_out[1]) begin r.hi1++; if (r.rise1 == 0) r.rise1 = k; end
            r.hirest += $countones(pwm_out[7:2]);
            if (wrap_o) begin r.per = k; break; end
        end
        wr_en = 1'b0;
    endtask

    task automatic cmp_res(input string tag, input res_t g, input res_t e);
        chk({tag, "_per"},    g.per,    e.per);
        chk({tag, "_hi0"},    g.hi0,    e.hi0);
        chk({tag, "_hi1"},    g.hi1,    e.hi1);
        chk({tag, "_hirest"}, g.hirest, e.hirest);
        chk({tag, "_rise0"},  g.rise0,  e.rise0);
        chk({tag, "_rise1"},  g.rise1,  e.rise1);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r, e;
        int n, hi, n_hi;

        //                presc  mask   d0      d1     nper per   hi0  hi1
        vt[0] = '{8'd0, 8'h00, 8'd50,  8'd50,  1, 256,  0,   0};
        vt[1] = '{8'd0, 8'h01, 8'd64,  8'd0,   2, 256,  64,  0};
        vt[2] = '{8'd0, 8'h01, 8'd0,   8'd0,   3, 256,  0,   0};
        vt[3] = '{8'd0, 8'h01, 8'd255, 8'd0,   3, 256,  256, 0};
        vt[4] = '{8'd3, 8'h02, 8'd0,   8'd128, 1, 1024, 0,   512};
        vt[5] = '{8'd0, 8'h03, 8'd1,   8'd254, 1, 256,  1,   254};
        vt[6] = '{8'd1, 8'h02, 8'd100, 8'd10,  1, 512,  0,   20};

        // Reset state, then idle run with no writes.
        rst_n = 1'b0; ena = 1'b1;
        step();
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_wrap", int'(wrap_o), 0);
        step();
        rst_n = 1'b1;
        wait_wrap(300, "idle_first", n, hi);
        chk("idle_first_wrap", n, 256);
        chk("idle_first_hi", hi, 0);
        run_period(-1, 4'h0, 8'h00, 300, r);
        chk("idle_per", r.per, 256);
        chk("idle_hi", r.hi0 + r.hi1 + r.hirest, 0);

        // Table-driven configurations scored per period.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            wr(ADDR_PRESC, vt[v].presc);
            wr(ADDR_EN, vt[v].mask);
            wr(ADDR_DUTY0, vt[v].d0);
            wr(ADDR_DUTY0 + 4'd1, vt[v].d1);
            for (int p = 0; p < vt[v].nper; p++) begin
                e = '{vt[v].e_per, vt[v].e_hi0, vt[v].e_hi1, 0,
                      (vt[v].e_hi0 > 0) ? 1 : 0, (vt[v].e_hi1 > 0) ? 1 : 0};
                sb.push_back(e);
            end
            wait_wrap(2100, $sformatf("v%0d", v), n, hi);
            for (int p = 0; p < vt[v].nper; p++) begin
                run_period(-1, 4'h0, 8'h00, 1100, r);
                e = sb.pop_front();
                cmp_res($sformatf("v%0d_p%0d", v, p), r, e);
            end
        end

        // PRESC rewrite mid-interval restarts the divider, stretching that period by 3 clocks.
        do_reset();
        wr(ADDR_PRESC, 8'd3);
        wait_wrap(2100, "presc_clr", n, hi);
        run_period(2, ADDR_PRESC, 8'd3, 1100, r);
        chk("presc_clr_per", r.per, 1027);

        // Asynchronous reset at counter 100.
        do_reset();
        wr(ADDR_EN, 8'h01);
        wr(ADDR_DUTY0, 8'd200);
        wait_wrap(300, "arst", n, hi);
        run_period(-1, 4'h0, 8'h00, 300, r);
        for (int i = 0; i < 100; i++) step();
        chk("arst_pre_high", int'(pwm_out[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_pwm_now", int'(pwm_out), 0);
        chk("arst_wrap_now", int'(wrap_o), 0);
        step();
        step();
        rst_n = 1'b1;
        wait_wrap(300, "arst_restart", n, hi);
        chk("arst_restart_wrap", n, 256);
        chk("arst_restart_hi", hi, 0);

        // ena dropped for 50 clocks at counter 100, with a duty write while held.
        do_reset();
        wr(ADDR_EN, 8'h01);
        wr(ADDR_DUTY0, 8'd128);
        wait_wrap(300, "ena", n, hi);
        run_period(-1, 4'h0, 8'h00, 300, r);
        for (int i = 0; i < 100; i++) step();
        chk("ena_pre_high", int'(pwm_out[0]), 1);
        ena = 1'b0;
        n_hi = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) begin
                wr_en = 1'b1; wr_addr = ADDR_DUTY0; wr_data = 8'd64;
            end else begin
                wr_en = 1'b0;
            end
            step();
            if (i == 0) chk("ena_off_pwm", int'(pwm_out), 0);
            if (pwm_out != '0 || wrap_o) n_hi++;
        end
        chk("ena_off_quiet", n_hi, 0);
        ena = 1'b1;
        wait_wrap(300, "ena_resume", n, hi);
        chk("ena_resume_wrap", n, 156);
        run_period(-1, 4'h0, 8'h00, 300, r);
        chk("ena_new_duty_hi", r.hi0, 64);
        chk("ena_new_duty_per", r.per, 256);

        // Duty update timing: mid-period write, then a write in the wrapping cycle.
        do_reset();
        wr(ADDR_EN, 8'h01);
        wr(ADDR_DUTY0, 8'd64);
        wait_wrap(300, "dupd", n, hi);
        run_period(-1, 4'h0, 8'h00, 300, r);
        chk("dupd_base_hi", r.hi0, 64);
        run_period(20, ADDR_DUTY0, 8'd192, 300, r);
        chk("dupd_mid_hi", r.hi0, SHADOW ? 64 : 192);
        run_period(-1, 4'h0, 8'h00, 300, r);
        chk("dupd_after_hi", r.hi0, 192);
        run_period(255, ADDR_DUTY0, 8'd32, 300, r);
        chk("dupd_wrapwr_per", r.per, 256);
        chk("dupd_wrapwr_hi", r.hi0, 192);
        run_period(-1, 4'h0, 8'h00, 300, r);
        chk("dupd_next_hi", r.hi0, SHADOW ? 192 : 32);
        run_period(-1, 4'h0, 8'h00, 300, r);
        chk("dupd_final_hi", r.hi0, 32);
        chk("dupd_final_rise", r.rise0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter N_CH, default 8; number of PWM channels, legal 1..8.
REQ-002 SHALL have parameter CNT_W, default 8; period counter and duty width, legal 4..8.
REQ-003 SHALL have port clk, input, 1; the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1; asynchronous active-low reset.
REQ-005 SHALL have port ena, input, 1; design-selected enable.
REQ-006 SHALL have port wr_en, input, 1; register write strobe, one write per cycle.
REQ-007 SHALL have port wr_addr, input, 4; register address.
REQ-008 SHALL have port wr_data, input, 8; write data.
REQ-009 SHALL have port pwm_out, output, N_CH; registered PWM outputs.
REQ-010 SHALL have port wrap_o, output, 1; one-cycle pulse on each period wrap.

Function
REQ-011 SHALL use this register map: 0x0 enable mask (bits N_CH-1:0), 0x1 prescaler PRESC (8b), 0x2..0x2+N_CH-1 duty of channel 0..N_CH-1 (low CNT_W bits); all other addresses SHALL be ignored.
REQ-012 SHALL run a prescaler counter that asserts tick every PRESC+1 clocks while ena=1; PRESC=0 means tick every clock.
REQ-013 SHALL increment the CNT_W-bit period counter on each tick, wrapping from 2^CNT_W-1 to 0.
REQ-014 SHALL assert wrap_o for exactly one clock on the cycle after the counter wraps to 0.
REQ-015 SHALL drive pwm_out[i] high when enable[i]=1 and either counter < active_duty[i], or active_duty[i] = 2^CNT_W-1 (constant high).
REQ-016 SHALL drive pwm_out[i] low when enable[i]=0 or active_duty[i]=0.
REQ-017 SHALL register pwm_out: the output reflects the counter value one clock later.
REQ-018 SHALL, when ena=0, hold both counters, force pwm_out and wrap_o low, and still accept register writes.
REQ-019 SHALL apply enable-mask and PRESC writes on the next clock; a PRESC write SHALL also clear the prescaler counter.

Reset
REQ-020 SHALL, while rst_n=0, asynchronously clear all counters, enable mask, PRESC, shadow and active duties; pwm_out=0, wrap_o=0.
REQ-021 SHALL, on reset mid-period, restart at counter 0 after release with no partial pulse retained.

Configuration
REQ-022 SHALL honour macro PWM_BANK_SHADOW_EN.
REQ-023 With PWM_BANK_SHADOW_EN defined: duty writes SHALL go to a shadow register, and active_duty SHALL load from the shadow on the tick that wraps the counter to 0.
REQ-024 With PWM_BANK_SHADOW_EN defined: a duty write in the same cycle as a wrap SHALL land in the shadow only and take effect at the following wrap.
REQ-025 Without PWM_BANK_SHADOW_EN: duty writes SHALL update active_duty on the next clock, and no shadow storage SHALL be synthesised.

Structure
REQ-026 SHALL take register address constants (ADDR_EN, ADDR_PRESC, ADDR_DUTY0) and a CNT_W legality check from shared package pwm_bank_pkg.
REQ-027 SHALL instantiate sub-module pwm_bank_chan N_CH times; each instance holds one duty/shadow pair and its compare/output register.

Verification
REQ-028 SHALL test: reset, ena=1, no writes -> pwm_out=0 and wrap_o pulses every 256 clocks (N_CH=8, CNT_W=8, PRESC=0).
REQ-029 SHALL test: en=0x01, duty0=64, PRESC=0 -> pwm_out[0] high 64 of every 256 clocks, first rising edge 1 clock after wrap.
REQ-030 SHALL test: duty0=0 -> pwm_out[0] constant low; duty0=255 -> pwm_out[0] constant high across at least 3 periods.
REQ-031 SHALL test: PRESC=3, duty1=128, en=0x02 -> period 1024 clocks, pwm_out[1] high 512 clocks.
REQ-032 SHALL test, with PWM_BANK_SHADOW_EN: duty0 64->192 written mid-period -> high time stays 64 until the next wrap, then 192; a write in the wrap cycle takes effect one period later.
REQ-033 SHALL test: rst_n pulsed low at counter=100, and ena dropped for 50 clocks -> outputs low immediately; after release, counting resumes from 0 and from the held value respectively.
